imm_gen_stage: RTL and testbench

Registered, parametrised immediate generator for the decode stage of the RV32I/RV64I core. It extracts and sign- or zero-extends the immediate for all six base immediate formats (I, S, B, U, J, CSR-zimm) to `XLEN` bits. It flags unsupported selector codes instead of silently producing a value. It sits between the fetch/decode register and the execute stage behind a valid/ready handshake, with an optional skid buffer, so back-pressure from execute never drops or duplicates an instruction.

---
 rtl/imm_gen_stage.sv | 134 +++++++++++++
 tb/tb_imm_gen_stage.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_stage.sv
// Decode-stage immediate generator: extends I/S/B/J/U/Z immediates to XLEN and flags illegal imm_src.
// One-cycle latency when empty; SKID=1 is a two-entry skid with registered in_ready, SKID=0 passes ready through.
`timescale 1ns/1ps

module imm_gen_stage #(
  parameter int XLEN = 32,
  parameter int SKID = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst,
  input  logic [2:0]      imm_src,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm_ext,
  output logic            imm_err
);

  if ((XLEN != 32 && XLEN != 64) || (SKID != 0 && SKID != 1)) begin : g_bad_param
    $error("imm_gen_stage: XLEN must be 32 or 64 and SKID must be 0 or 1");
  end

  localparam logic [2:0] SRC_I = 3'b000;
  localparam logic [2:0] SRC_S = 3'b001;
  localparam logic [2:0] SRC_B = 3'b010;
  localparam logic [2:0] SRC_J = 3'b011;
  localparam logic [2:0] SRC_U = 3'b100;
  localparam logic [2:0] SRC_Z = 3'b101;

  typedef struct packed {
    logic            err;
    logic [XLEN-1:0] imm;
  } entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  entry_t      main_q, main_d;
  entry_t      skid_q, skid_d;
  entry_t      new_entry;
  logic [63:0] imm_wide;
  logic        new_err;
  logic        accept;
  logic        drain;

  // Built at 64 bits and truncated, so XLEN=32 needs no zero-width replications.
  always_comb begin
    imm_wide = '0;
    new_err  = 1'b0;
    case (imm_src)
      SRC_I:   imm_wide = {{53{inst[31]}}, inst[30:20]};
      SRC_S:   imm_wide = {{53{inst[31]}}, inst[30:25], inst[11:7]};
      SRC_B:   imm_wide = {{52{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
      SRC_J:   imm_wide = {{44{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
      SRC_U:   imm_wide = {{32{inst[31]}}, inst[31:12], 12'b0};
      SRC_Z:   imm_wide = {59'b0, inst[19:15]};
      default: new_err  = 1'b1;
    endcase
    new_entry.err = new_err;
    new_entry.imm = imm_wide[XLEN-1:0];
  end

  // Opcode bits and the unused upper half of imm_wide carry no immediate data.
  logic unused_bits;
  assign unused_bits = ^{inst[6:0], imm_wide};

  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;
  assign imm_ext   = main_q.imm;
  assign imm_err   = main_q.err;

  if (SKID != 0) begin : g_skid
    logic rdy_q;
    always_ff @(posedge clk) begin
      if (rst) rdy_q <= 1'b1;
      else     rdy_q <= (state_d != ST_FULL);
    end
    assign in_ready = rdy_q;
  end else begin : g_pass
    assign in_ready = (state_q == ST_EMPTY) || out_ready;
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          main_d  = new_entry;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && drain) begin
          main_d = new_entry;
        end else if (accept && (SKID != 0)) begin
          skid_d  = new_entry;
          state_d = ST_FULL;
        end else if (drain) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so the only event is main draining.
        if (drain) begin
          main_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed and randomised checks of imm_gen_stage in three configurations:
// XLEN=32/SKID=1, XLEN=32/SKID=0 and XLEN=64/SKID=1.
`timescale 1ns/1ps

module tb_imm_gen_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst;
  logic [2:0]  imm_src;

  logic        in_valid_s1, in_ready_s1, out_valid_s1, out_ready_s1, imm_err_s1;
  logic [31:0] imm_ext_s1;
  logic        in_valid_s0, in_ready_s0, out_valid_s0, out_ready_s0, imm_err_s0;
  logic [31:0] imm_ext_s0;
  logic        in_valid_x64, in_ready_x64, out_valid_x64, out_ready_x64, imm_err_x64;
  logic [63:0] imm_ext_x64;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] v_inst [8];
  logic [2:0]  v_src  [8];
  logic [31:0] v_exp  [8];
  logic        v_err  [8];

  always #5 clk = ~clk;

  imm_gen_stage #(.XLEN(32), .SKID(1)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_s1), .in_ready(in_ready_s1),
    .inst(inst), .imm_src(imm_src), .out_valid(out_valid_s1), .out_ready(out_ready_s1),
    .imm_ext(imm_ext_s1), .imm_err(imm_err_s1));

  imm_gen_stage #(.XLEN(32), .SKID(0)) u_s0 (
    .clk(clk), .rst(rst), .in_valid(in_valid_s0), .in_ready(in_ready_s0),
    .inst(inst), .imm_src(imm_src), .out_valid(out_valid_s0), .out_ready(out_ready_s0),
    .imm_ext(imm_ext_s0), .imm_err(imm_err_s0));

  imm_gen_stage #(.XLEN(64), .SKID(1)) u_x64 (
    .clk(clk), .rst(rst), .in_valid(in_valid_x64), .in_ready(in_ready_x64),
    .inst(inst), .imm_src(imm_src), .out_valid(out_valid_x64), .out_ready(out_ready_x64),
    .imm_ext(imm_ext_x64), .imm_err(imm_err_x64));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_vec(input int idx);
    inst    = v_inst[idx];
    imm_src = v_src[idx];
  endtask

  task automatic test_reset;
    rst = 1'b1;
    in_valid_s1 = 1'b1; in_valid_s0 = 1'b1; in_valid_x64 = 1'b1;
    out_ready_s1 = 1'b0; out_ready_s0 = 1'b0; out_ready_x64 = 1'b0;
    load_vec(0);
    tick;
    tick;
    tests_run++;
    if (out_valid_s1 !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid_s1: got %b want 0", out_valid_s1); end
    tests_run++;
    if (imm_ext_s1 !== 32'h0) begin tests_failed++; $display("FAIL reset_imm_ext_s1: got %h want 0", imm_ext_s1); end
    tests_run++;
    if (imm_err_s1 !== 1'b0) begin tests_failed++; $display("FAIL reset_imm_err_s1: got %b want 0", imm_err_s1); end
    tests_run++;
    if (in_ready_s1 !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready_s1: got %b want 1", in_ready_s1); end
    tests_run++;
    if (out_valid_s0 !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid_s0: got %b want 0", out_valid_s0); end
    tests_run++;
    if (in_ready_s0 !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready_s0: got %b want 1", in_ready_s0); end
    tests_run++;
    if (out_valid_x64 !== 1'b0 || imm_ext_x64 !== 64'h0) begin
      tests_failed++; $display("FAIL reset_x64: got valid %b imm %h want 0/0", out_valid_x64, imm_ext_x64);
    end
    rst = 1'b0;
    in_valid_s1 = 1'b0; in_valid_s0 = 1'b0; in_valid_x64 = 1'b0;
    tick;
    tests_run++;
    if (out_valid_s1 !== 1'b0) begin tests_failed++; $display("FAIL reset_discard_s1: got valid %b want 0", out_valid_s1); end
  endtask

  task automatic test_stream;
    out_ready_s1 = 1'b1; out_ready_s0 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      load_vec(i);
      in_valid_s1 = 1'b1; in_valid_s0 = 1'b1;
      #1;
      tests_run++;
      if (in_ready_s1 !== 1'b1 || in_ready_s0 !== 1'b1) begin
        tests_failed++; $display("FAIL stream_in_ready[%0d]: got s1 %b s0 %b want 1/1", i, in_ready_s1, in_ready_s0);
      end
      tick;
      tests_run++;
      if (out_valid_s1 !== 1'b1 || imm_ext_s1 !== v_exp[i] || imm_err_s1 !== 1'b0) begin
        tests_failed++;
        $display("FAIL stream_s1[%0d]: got v%b %h e%b want v1 %h e0", i, out_valid_s1, imm_ext_s1, imm_err_s1, v_exp[i]);
      end
      tests_run++;
      if (out_valid_s0 !== 1'b1 || imm_ext_s0 !== v_exp[i] || imm_err_s0 !== 1'b0) begin
        tests_failed++;
        $display("FAIL stream_s0[%0d]: got v%b %h e%b want v1 %h e0", i, out_valid_s0, imm_ext_s0, imm_err_s0, v_exp[i]);
      end
    end
    in_valid_s1 = 1'b0; in_valid_s0 = 1'b0;
    tick;
    tests_run++;
    if (out_valid_s1 !== 1'b0 || out_valid_s0 !== 1'b0) begin
      tests_failed++; $display("FAIL stream_drained: got s1 %b s0 %b want 0/0", out_valid_s1, out_valid_s0);
    end
  endtask

  task automatic test_illegal;
    int seq [3];
    seq = '{6, 7, 0};
    out_ready_s1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      load_vec(seq[k]);
      in_valid_s1 = 1'b1;
      tick;
      tests_run++;
      if (out_valid_s1 !== 1'b1 || imm_ext_s1 !== v_exp[seq[k]] || imm_err_s1 !== v_err[seq[k]]) begin
        tests_failed++;
        $display("FAIL illegal[%0d]: got v%b %h e%b want v1 %h e%b", k, out_valid_s1, imm_ext_s1, imm_err_s1,
                 v_exp[seq[k]], v_err[seq[k]]);
      end
    end
    in_valid_s1 = 1'b0;
    tick;
  endtask

  task automatic test_xlen64;
    logic [31:0] xi [4];
    logic [2:0]  xs [4];
    logic [63:0] xe [4];
    xi = '{32'h823450B7, 32'h7FF00093, 32'h000FD073, 32'hFE000CE3};
    xs = '{3'b100, 3'b000, 3'b101, 3'b010};
    xe = '{64'hFFFFFFFF82345000, 64'h00000000000007FF, 64'h000000000000001F, 64'hFFFFFFFFFFFFFFF8};
    out_ready_x64 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      inst = xi[k]; imm_src = xs[k];
      in_valid_x64 = 1'b1;
      tick;
      tests_run++;
      if (out_valid_x64 !== 1'b1 || imm_ext_x64 !== xe[k] || imm_err_x64 !== 1'b0) begin
        tests_failed++;
        $display("FAIL xlen64[%0d]: got v%b %h e%b want v1 %h e0", k, out_valid_x64, imm_ext_x64, imm_err_x64, xe[k]);
      end
    end
    in_valid_x64 = 1'b0;
    tick;
  endtask

  task automatic test_backpressure;
    // A=I(all ones), B=U(0x12345000), C=Z(1)
    out_ready_s1 = 1'b0;
    load_vec(0); in_valid_s1 = 1'b1;
    tick;
    tests_run++;
    if (out_valid_s1 !== 1'b1 || imm_ext_s1 !== 32'hFFFFFFFF || in_ready_s1 !== 1'b1) begin
      tests_failed++; $display("FAIL bp_take_a: got v%b %h r%b want v1 ffffffff r1", out_valid_s1, imm_ext_s1, in_ready_s1);
    end
    load_vec(4);
    tick;
    tests_run++;
    if (imm_ext_s1 !== 32'hFFFFFFFF || in_ready_s1 !== 1'b0) begin
      tests_failed++; $display("FAIL bp_take_b: got %h r%b want ffffffff r0", imm_ext_s1, in_ready_s1);
    end
    load_vec(5);
    for (int k = 0; k < 2; k++) begin
      tick;
      tests_run++;
      if (out_valid_s1 !== 1'b1 || imm_ext_s1 !== 32'hFFFFFFFF || in_ready_s1 !== 1'b0) begin
        tests_failed++;
        $display("FAIL bp_stall[%0d]: got v%b %h r%b want v1 ffffffff r0", k, out_valid_s1, imm_ext_s1, in_ready_s1);
      end
    end
    out_ready_s1 = 1'b1;
    tick;
    tests_run++;
    if (out_valid_s1 !== 1'b1 || imm_ext_s1 !== 32'h12345000 || in_ready_s1 !== 1'b1) begin
      tests_failed++; $display("FAIL bp_out_b: got v%b %h r%b want v1 12345000 r1", out_valid_s1, imm_ext_s1, in_ready_s1);
    end
    tick;
    in_valid_s1 = 1'b0;
    tests_run++;
    if (out_valid_s1 !== 1'b1 || imm_ext_s1 !== 32'h00000001) begin
      tests_failed++; $display("FAIL bp_out_c: got v%b %h want v1 00000001", out_valid_s1, imm_ext_s1);
    end
    tick;
    tests_run++;
    if (out_valid_s1 !== 1'b0) begin tests_failed++; $display("FAIL bp_no_dup: got valid %b want 0", out_valid_s1); end
  endtask

  task automatic test_reset_full;
    out_ready_s1 = 1'b0;
    load_vec(0); in_valid_s1 = 1'b1;
    tick;
    load_vec(4);
    tick;
    in_valid_s1 = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    tests_run++;
    if (out_valid_s1 !== 1'b0 || imm_ext_s1 !== 32'h0 || imm_err_s1 !== 1'b0 || in_ready_s1 !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_full: got v%b %h e%b r%b want v0 0 e0 r1", out_valid_s1, imm_ext_s1, imm_err_s1, in_ready_s1);
    end
    load_vec(1); in_valid_s1 = 1'b1;
    tick;
    in_valid_s1 = 1'b0; out_ready_s1 = 1'b1;
    tests_run++;
    if (out_valid_s1 !== 1'b1 || imm_ext_s1 !== 32'hFFFFFFFC) begin
      tests_failed++; $display("FAIL rst_first_entry: got v%b %h want v1 fffffffc", out_valid_s1, imm_ext_s1);
    end
    tick;
    tests_run++;
    if (out_valid_s1 !== 1'b0) begin tests_failed++; $display("FAIL rst_drain: got valid %b want 0", out_valid_s1); end
  endtask

  task automatic test_stress;
    int q1 [$];
    int q0 [$];
    int idx;
    logic rdy1, rdy0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      idx = $urandom_range(0, 7);
      load_vec(idx);
      in_valid_s1  = 1'($urandom_range(0, 1));
      in_valid_s0  = 1'($urandom_range(0, 1));
      out_ready_s1 = 1'($urandom_range(0, 1));
      out_ready_s0 = 1'($urandom_range(0, 1));
      #1;
      rdy1 = (q1.size() < 2);
      rdy0 = (q0.size() == 0) || out_ready_s0;
      tests_run++;
      if (in_ready_s1 !== rdy1 || out_valid_s1 !== (q1.size() != 0)) begin
        tests_failed++;
        $display("FAIL stress_s1_hs[%0d]: got r%b v%b want r%b v%b", cyc, in_ready_s1, out_valid_s1, rdy1, q1.size() != 0);
      end
      tests_run++;
      if (in_ready_s0 !== rdy0 || out_valid_s0 !== (q0.size() != 0)) begin
        tests_failed++;
        $display("FAIL stress_s0_hs[%0d]: got r%b v%b want r%b v%b", cyc, in_ready_s0, out_valid_s0, rdy0, q0.size() != 0);
      end
      if (q1.size() != 0) begin
        tests_run++;
        if (imm_ext_s1 !== v_exp[q1[0]] || imm_err_s1 !== v_err[q1[0]]) begin
          tests_failed++;
          $display("FAIL stress_s1_data[%0d]: got %h e%b want %h e%b", cyc, imm_ext_s1, imm_err_s1, v_exp[q1[0]], v_err[q1[0]]);
        end
        if (out_ready_s1) void'(q1.pop_front());
      end
      if (q0.size() != 0) begin
        tests_run++;
        if (imm_ext_s0 !== v_exp[q0[0]] || imm_err_s0 !== v_err[q0[0]]) begin
          tests_failed++;
          $display("FAIL stress_s0_data[%0d]: got %h e%b want %h e%b", cyc, imm_ext_s0, imm_err_s0, v_exp[q0[0]], v_err[q0[0]]);
        end
        if (out_ready_s0) void'(q0.pop_front());
      end
      if (in_valid_s1 && rdy1) q1.push_back(idx);
      if (in_valid_s0 && rdy0) q0.push_back(idx);
      tick;
    end
    in_valid_s1 = 1'b0; in_valid_s0 = 1'b0;
    out_ready_s1 = 1'b1; out_ready_s0 = 1'b1;
    repeat (3) tick;
    tests_run++;
    if (out_valid_s1 !== 1'b0 || out_valid_s0 !== 1'b0) begin
      tests_failed++; $display("FAIL stress_final_drain: got s1 %b s0 %b want 0/0", out_valid_s1, out_valid_s0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    v_inst = '{32'hFFF00093, 32'hFE20AE23, 32'hFE000CE3, 32'hFFDFF06F,
               32'h123450B7, 32'h3400D073, 32'hDEADBEEF, 32'hFFFFFFFF};
    v_src  = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
    v_exp  = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'hFFFFFFFC,
               32'h12345000, 32'h00000001, 32'h00000000, 32'h00000000};
    v_err  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    rst = 1'b1;
    inst = 32'h0; imm_src = 3'b000;
    in_valid_s1 = 1'b0; in_valid_s0 = 1'b0; in_valid_x64 = 1'b0;
    out_ready_s1 = 1'b0; out_ready_s0 = 1'b0; out_ready_x64 = 1'b0;

    test_reset;
    test_stream;
    test_illegal;
    test_xlen64;
    test_backpressure;
    test_reset_full;
    test_stress;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
